// File: rtl/object_table_n_if.sv
// object_table_n write port: valid/ready handshake carrying one slot update.
// master = game logic, slave = object table.
interface object_table_n_if #(
  parameter int NUM_OBJ = 8,
  parameter int COORD_W = 11,
  parameter int IMG_W   = 8
);
  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  logic               wr_valid;
  logic               wr_ready;
  logic [IDX_W-1:0]   wr_idx;
  logic               wr_visible;
  logic [IMG_W-1:0]   wr_img_id;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic [COORD_W-1:0] wr_w;
  logic [COORD_W-1:0] wr_h;

  modport master (
    output wr_valid, wr_idx, wr_visible, wr_img_id,
    output wr_x, wr_y, wr_w, wr_h,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_idx, wr_visible, wr_img_id,
    input  wr_x, wr_y, wr_w, wr_h,
    output wr_ready
  );
endinterface

// File: rtl/object_table_n.sv
// Double-buffered sprite table with 2-cycle per-pixel priority hit query.
// Optional OBJECT_TABLE_COLLISION_FLAGS_EN adds sticky per-slot overlap flags.
module object_table_n #(
  parameter int NUM_OBJ = 8,
  parameter int COORD_W = 11,
  parameter int IMG_W   = 8,
  localparam int IDX_W  = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               frame_start,
  object_table_n_if.slave    wr,
  input  logic               req_valid,
  input  logic [COORD_W-1:0] requested_x,
  input  logic [COORD_W-1:0] requested_y,
  output logic               out_valid,
  output logic               hit,
  output logic [IDX_W-1:0]   hit_idx,
  output logic [IMG_W-1:0]   img_id,
  output logic [COORD_W-1:0] x_offset,
  output logic [COORD_W-1:0] y_offset,
  output logic [NUM_OBJ-1:0] collision_vec
);

  typedef struct packed {
    logic               vis;
    logic [IMG_W-1:0]   img;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
  } obj_t;

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t state, state_nxt;
  logic   rdy_q;
  logic   wr_fire;
  obj_t   shadow [NUM_OBJ];
  obj_t   active [NUM_OBJ];

  logic [NUM_OBJ-1:0] hv;
  logic [COORD_W-1:0] xo [NUM_OBJ];
  logic [COORD_W-1:0] yo [NUM_OBJ];

  logic               s1_valid;
  logic [NUM_OBJ-1:0] s1_hit;
  logic [COORD_W-1:0] s1_xo  [NUM_OBJ];
  logic [COORD_W-1:0] s1_yo  [NUM_OBJ];
  logic [IMG_W-1:0]   s1_img [NUM_OBJ];

  logic               pe_found;
  logic [IDX_W-1:0]   pe_idx;
  logic [IMG_W-1:0]   pe_img;
  logic [COORD_W-1:0] pe_xo;
  logic [COORD_W-1:0] pe_yo;

  // ready only comes up once the table is out of reset
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) rdy_q <= 1'b0;
    else         rdy_q <= 1'b1;
  end

  assign wr.wr_ready = rdy_q & ~frame_start;
  assign wr_fire     = wr.wr_valid & wr.wr_ready;

  // commit FSM state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // commit FSM next state; frame_start during COMMIT is ignored
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_start) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // shadow table: whole-slot update; out-of-range index matches nothing
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_OBJ; i++) shadow[i] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (32'(wr.wr_idx) == i) begin
          shadow[i] <= '{vis: wr.wr_visible,
                         img: wr.wr_img_id,
                         x:   wr.wr_x,
                         y:   wr.wr_y,
                         w:   wr.wr_w,
                         h:   wr.wr_h};
        end
      end
    end
  end

  // active table: bulk copy during COMMIT
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_OBJ; i++) active[i] <= '0;
    end else if (state == COMMIT) begin
      for (int i = 0; i < NUM_OBJ; i++) active[i] <= shadow[i];
    end
  end

  // per-slot hit test; right/bottom edges one bit wider so nothing wraps
  always_comb begin
    hv = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      xo[i] = requested_x - active[i].x;
      yo[i] = requested_y - active[i].y;
      hv[i] = req_valid && active[i].vis
        && (requested_x >= active[i].x)
        && ({1'b0, requested_x} <
            {1'b0, active[i].x} + {1'b0, active[i].w})
        && (requested_y >= active[i].y)
        && ({1'b0, requested_y} <
            {1'b0, active[i].y} + {1'b0, active[i].h});
    end
  end

  // stage 1: capture slot results with their image ids so a commit
  // landing mid-pipeline cannot change an in-flight answer
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_valid <= 1'b0;
      s1_hit   <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        s1_xo[i]  <= '0;
        s1_yo[i]  <= '0;
        s1_img[i] <= '0;
      end
    end else begin
      s1_valid <= req_valid;
      s1_hit   <= hv;
      for (int i = 0; i < NUM_OBJ; i++) begin
        s1_xo[i]  <= xo[i];
        s1_yo[i]  <= yo[i];
        s1_img[i] <= active[i].img;
      end
    end
  end

  // priority encoder: scan high to low so the lowest index wins
  always_comb begin
    pe_found = 1'b0;
    pe_idx   = '0;
    pe_img   = '1;
    pe_xo    = '0;
    pe_yo    = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        pe_found = 1'b1;
        pe_idx   = IDX_W'(i);
        pe_img   = s1_img[i];
        pe_xo    = s1_xo[i];
        pe_yo    = s1_yo[i];
      end
    end
  end

  // stage 2: outputs hold while no result is valid
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      out_valid <= 1'b0;
      hit       <= 1'b0;
      hit_idx   <= '0;
      img_id    <= '0;
      x_offset  <= '0;
      y_offset  <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        hit      <= pe_found;
        hit_idx  <= pe_idx;
        img_id   <= pe_img;
        x_offset <= pe_xo;
        y_offset <= pe_yo;
      end
    end
  end

`ifdef OBJECT_TABLE_COLLISION_FLAGS_EN
  logic [NUM_OBJ-1:0] flags;
  logic [NUM_OBJ-1:0] col_set;

  assign col_set =
    (|(s1_hit & (s1_hit - NUM_OBJ'(1)))) ? s1_hit : '0;

  // sticky overlap flags, snapshotted and restarted each frame
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      flags         <= '0;
      collision_vec <= '0;
    end else if (frame_start) begin
      collision_vec <= flags;
      flags         <= col_set;
    end else begin
      flags <= flags | col_set;
    end
  end
`else
  assign collision_vec = '0;
`endif

endmodule

// File: tb/tb_object_table_n.sv
// Directed bench for object_table_n: commit timing, priority,
// handshake vs frame_start, coordinate edges, optional overlap flags.
module tb_object_table_n;
  localparam int NUM_OBJ = 8;
  localparam int COORD_W = 11;
  localparam int IMG_W   = 8;
  localparam int IDX_W   = 3;

  logic               clk;
  logic               resetN;
  logic               frame_start;
  logic               req_valid;
  logic [COORD_W-1:0] requested_x;
  logic [COORD_W-1:0] requested_y;
  logic               out_valid;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [IMG_W-1:0]   img_id;
  logic [COORD_W-1:0] x_offset;
  logic [COORD_W-1:0] y_offset;
  logic [NUM_OBJ-1:0] collision_vec;

  int n_chk = 0;
  int n_err = 0;

  object_table_n_if #(
    .NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W), .IMG_W(IMG_W)
  ) wif ();

  object_table_n #(
    .NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W), .IMG_W(IMG_W)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .frame_start   (frame_start),
    .wr            (wif.slave),
    .req_valid     (req_valid),
    .requested_x   (requested_x),
    .requested_y   (requested_y),
    .out_valid     (out_valid),
    .hit           (hit),
    .hit_idx       (hit_idx),
    .img_id        (img_id),
    .x_offset      (x_offset),
    .y_offset      (y_offset),
    .collision_vec (collision_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_slot(input int idx, input bit vis,
                         input int img, input int x, input int y,
                         input int w, input int h);
    wif.wr_valid   = 1'b1;
    wif.wr_idx     = IDX_W'(idx);
    wif.wr_visible = vis;
    wif.wr_img_id  = IMG_W'(img);
    wif.wr_x       = COORD_W'(x);
    wif.wr_y       = COORD_W'(y);
    wif.wr_w       = COORD_W'(w);
    wif.wr_h       = COORD_W'(h);
    step();
    wif.wr_valid = 1'b0;
  endtask

  task automatic commit();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
  endtask

  task automatic query(input string tag, input int x, input int y,
                       input bit e_hit, input int e_idx,
                       input int e_img, input int e_xo,
                       input int e_yo);
    req_valid   = 1'b1;
    requested_x = COORD_W'(x);
    requested_y = COORD_W'(y);
    step();
    req_valid = 1'b0;
    check({tag, ".lat1"}, 32'(out_valid), 0);
    step();
    check({tag, ".valid"}, 32'(out_valid), 1);
    check({tag, ".hit"}, 32'(hit), 32'(e_hit));
    check({tag, ".idx"}, 32'(hit_idx), e_idx);
    check({tag, ".img"}, 32'(img_id), e_img);
    check({tag, ".xo"}, 32'(x_offset), e_xo);
    check({tag, ".yo"}, 32'(y_offset), e_yo);
  endtask

  initial begin
    resetN         = 1'b0;
    frame_start    = 1'b0;
    req_valid      = 1'b0;
    requested_x    = '0;
    requested_y    = '0;
    wif.wr_valid   = 1'b0;
    wif.wr_idx     = '0;
    wif.wr_visible = 1'b0;
    wif.wr_img_id  = '0;
    wif.wr_x       = '0;
    wif.wr_y       = '0;
    wif.wr_w       = '0;
    wif.wr_h       = '0;

    #12;
    check("rst.ready", 32'(wif.wr_ready), 0);
    check("rst.valid", 32'(out_valid), 0);
    check("rst.hit", 32'(hit), 0);
    check("rst.img", 32'(img_id), 0);
    check("rst.col", 32'(collision_vec), 0);
    #10;
    resetN = 1'b1;
    check("rel.ready", 32'(wif.wr_ready), 0);
    step();
    check("up.ready", 32'(wif.wr_ready), 1);

    wr_slot(0, 1, 5, 100, 50, 16, 32);
    query("precommit", 100, 50, 0, 0, 255, 0, 0);

    commit();
    query("tl", 100, 50, 1, 0, 5, 0, 0);
    query("br", 115, 81, 1, 0, 5, 15, 31);
    query("right", 116, 50, 0, 0, 255, 0, 0);

    wr_slot(3, 1, 9, 100, 50, 8, 8);
    commit();
    query("prio0", 104, 52, 1, 0, 5, 4, 2);
    wr_slot(0, 0, 5, 100, 50, 16, 32);
    commit();
    query("prio3", 104, 52, 1, 3, 9, 4, 2);

    frame_start    = 1'b1;
    wif.wr_valid   = 1'b1;
    wif.wr_idx     = IDX_W'(3);
    wif.wr_visible = 1'b1;
    wif.wr_img_id  = IMG_W'(7);
    wif.wr_x       = COORD_W'(300);
    wif.wr_y       = COORD_W'(200);
    wif.wr_w       = COORD_W'(4);
    wif.wr_h       = COORD_W'(4);
    #1;
    check("fs.ready", 32'(wif.wr_ready), 0);
    step();
    frame_start   = 1'b0;
    wif.wr_img_id = IMG_W'(8);
    wif.wr_x      = COORD_W'(200);
    #1;
    check("hold.ready", 32'(wif.wr_ready), 1);
    step();
    wif.wr_valid = 1'b0;
    query("fs.old", 104, 52, 1, 3, 9, 4, 2);
    query("fs.drop", 301, 201, 0, 0, 255, 0, 0);
    commit();
    query("fs.new", 201, 201, 1, 3, 8, 1, 1);

    wr_slot(5, 1, 8'h22, 2040, 10, 20, 4);
    wr_slot(6, 1, 8'h33, 0, 20, 0, 4);
    commit();
    query("edge", 2047, 10, 1, 5, 8'h22, 7, 0);
    query("nowrap", 3, 10, 0, 0, 255, 0, 0);
    query("w0", 0, 20, 0, 0, 255, 0, 0);

`ifdef OBJECT_TABLE_COLLISION_FLAGS_EN
    wr_slot(1, 1, 1, 500, 500, 10, 10);
    wr_slot(2, 1, 2, 505, 505, 10, 10);
    commit();
    check("col.clear", 32'(collision_vec), 0);
    query("ovl", 507, 507, 1, 1, 1, 7, 7);
    commit();
    check("col.set", 32'(collision_vec), 32'h06);
    commit();
    check("col.next", 32'(collision_vec), 0);
`else
    check("col.off", 32'(collision_vec), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
